high_freq_queue: RTL and testbench

HIGH_FREQ_QUEUE -- requirements
Module: high_freq_queue

---
 rtl/high_freq_queue_if.sv | 21 ++
 rtl/high_freq_queue.sv | 96 +++++++++
 tb/tb_high_freq_queue.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/high_freq_queue_if.sv
// Stereo sample queue handshake: write strobe and samples in, burst readout out.
interface high_freq_queue_if #(
  parameter int DATA_W = 16
);
  logic                     wrt_smpl;
  logic signed [DATA_W-1:0] lft_smpl;
  logic signed [DATA_W-1:0] rght_smpl;
  logic signed [DATA_W-1:0] lft_out;
  logic signed [DATA_W-1:0] rght_out;
  logic                     sequencing;

  modport master (
    output wrt_smpl, lft_smpl, rght_smpl,
    input  lft_out, rght_out, sequencing
  );

  modport slave (
    input  wrt_smpl, lft_smpl, rght_smpl,
    output lft_out, rght_out, sequencing
  );
endinterface

// File: rtl/high_freq_queue.sv
// Circular stereo sample store; every new sample (once full) replays the newest
// TAPS samples oldest-first as a contiguous burst for a FIR engine.
module high_freq_queue #(
  parameter int DEPTH  = 1024,
  parameter int TAPS   = 1021,
  parameter int DATA_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  high_freq_queue_if.slave q
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {FILL, IDLE, SEQ} state_t;

  state_t                   state;
  logic [PTR_W-1:0]         new_ptr;
  logic [PTR_W-1:0]         new_ptr_nxt;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         fill_cnt;
  logic [CNT_W-1:0]         rd_cnt;
  logic                     pending;
  logic                     start_seq;
  logic signed [DATA_W-1:0] mem_l [DEPTH];
  logic signed [DATA_W-1:0] mem_r [DEPTH];
  logic signed [DATA_W-1:0] lft_p1;
  logic signed [DATA_W-1:0] rght_p1;
  logic                     vld_p1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Oldest slot of the window that ends just before p, modulo DEPTH.
  function automatic logic [PTR_W-1:0] ptr_back(input logic [PTR_W-1:0] p);
    return (p >= PTR_W'(TAPS)) ? p - PTR_W'(TAPS) : p + PTR_W'(DEPTH - TAPS);
  endfunction

  assign new_ptr_nxt = q.wrt_smpl ? ptr_inc(new_ptr) : new_ptr;

  assign start_seq = ((state == IDLE) && (q.wrt_smpl || pending)) ||
                     ((state == FILL) && q.wrt_smpl && (fill_cnt == CNT_W'(TAPS - 1)));

  // Stage p0: sample write into the circular arrays (contents never reset).
  always_ff @(posedge clk) begin
    if (q.wrt_smpl) begin
      mem_l[new_ptr] <= q.lft_smpl;
      mem_r[new_ptr] <= q.rght_smpl;
    end
  end

  // Stage p1: registered read, pointer and burst control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      new_ptr  <= '0;
      rd_ptr   <= '0;
      fill_cnt <= '0;
      rd_cnt   <= '0;
      pending  <= 1'b0;
      lft_p1   <= '0;
      rght_p1  <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= (state == SEQ);
      if (q.wrt_smpl) begin
        new_ptr <= new_ptr_nxt;
        if (fill_cnt != CNT_W'(TAPS))
          fill_cnt <= fill_cnt + 1'b1;
      end
      if (start_seq) begin
        state   <= SEQ;
        rd_ptr  <= ptr_back(new_ptr_nxt);
        rd_cnt  <= '0;
        pending <= 1'b0;
      end else if (state == SEQ) begin
        lft_p1  <= mem_l[rd_ptr];
        rght_p1 <= mem_r[rd_ptr];
        rd_ptr  <= ptr_inc(rd_ptr);
        rd_cnt  <= rd_cnt + 1'b1;
        // A write here (including the final read cycle) queues the next burst.
        if (q.wrt_smpl)
          pending <= 1'b1;
        if (rd_cnt == CNT_W'(TAPS - 1))
          state <= IDLE;
      end
    end
  end

  assign q.lft_out    = lft_p1;
  assign q.rght_out   = rght_p1;
  assign q.sequencing = vld_p1;

endmodule

// File: tb/tb_high_freq_queue.sv
// Directed bench for high_freq_queue: fill, burst timing, pending bursts, wrap, sign, reset.
module tb_high_freq_queue;
  localparam int DEPTH = 1024;
  localparam int TAPS  = 1021;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  high_freq_queue_if #(.DATA_W(16)) q ();

  high_freq_queue #(.DEPTH(DEPTH), .TAPS(TAPS), .DATA_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (q)
  );

  int checks   = 0;
  int failures = 0;
  logic signed [15:0] cap_l [TAPS+8];
  logic signed [15:0] cap_r [TAPS+8];
  int cap_len;
  int cap_wait;
  int bad_idx;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_smpl(input int v);
    q.wrt_smpl  = 1'b1;
    q.lft_smpl  = 16'(v);
    q.rght_smpl = 16'(-v);
    step();
    q.wrt_smpl  = 1'b0;
  endtask

  // Waits (bounded) for sequencing, then records the burst; optionally writes
  // samples inj_base.. while burst sample indices inj_start.. are on the outputs.
  task automatic capture(input int inj_start, input int inj_cnt, input int inj_base);
    cap_wait = 0;
    cap_len  = 0;
    while (q.sequencing !== 1'b1 && cap_wait < 3000) begin
      step();
      cap_wait++;
    end
    if (q.sequencing !== 1'b1) begin
      cap_wait = -1;
      return;
    end
    while (q.sequencing === 1'b1 && cap_len < TAPS + 8) begin
      cap_l[cap_len] = q.lft_out;
      cap_r[cap_len] = q.rght_out;
      if (cap_len >= inj_start && cap_len < inj_start + inj_cnt) begin
        q.wrt_smpl  = 1'b1;
        q.lft_smpl  = 16'(inj_base + cap_len - inj_start);
        q.rght_smpl = 16'(-(inj_base + cap_len - inj_start));
      end else begin
        q.wrt_smpl = 1'b0;
      end
      cap_len++;
      step();
    end
    q.wrt_smpl = 1'b0;
  endtask

  function automatic int burst_bad(input int first);
    int n = 0;
    logic signed [15:0] el, er;
    for (int j = 0; j < TAPS; j++) begin
      el = 16'(first + j);
      er = 16'(-(first + j));
      if (cap_l[j] !== el || cap_r[j] !== er) begin
        if (n == 0) bad_idx = j;
        n++;
      end
    end
    return n;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    q.wrt_smpl = 1'b0; q.lft_smpl = '0; q.rght_smpl = '0;
    step(); step();
    checks++; if (q.sequencing !== 1'b0) begin failures++; $display("FAIL reset_seq got=%b want=0", q.sequencing); end
    checks++; if (q.lft_out !== 16'sd0) begin failures++; $display("FAIL reset_lft got=%0d want=0", q.lft_out); end
    checks++; if (q.rght_out !== 16'sd0) begin failures++; $display("FAIL reset_rght got=%0d want=0", q.rght_out); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill();
    int seen = 0;
    for (int k = 0; k < TAPS - 1; k++) begin
      write_smpl(k);
      if (q.sequencing === 1'b1) seen++;
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if (q.sequencing === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL fill_no_seq high_cycles=%0d want=0", seen); end
  endtask

  task automatic test_first_burst();
    int nb;
    write_smpl(TAPS - 1);
    capture(-1, 0, 0);
    checks++; if (cap_wait !== 1) begin failures++; $display("FAIL first_latency got=%0d want=1", cap_wait); end
    checks++; if (cap_len !== TAPS) begin failures++; $display("FAIL first_len got=%0d want=%0d", cap_len, TAPS); end
    nb = burst_bad(0);
    checks++; if (nb !== 0) begin failures++; $display("FAIL first_data bad=%0d idx=%0d got=%0d/%0d want=%0d", nb, bad_idx, cap_l[bad_idx], cap_r[bad_idx], bad_idx); end
    for (int i = 0; i < 4; i++) step();
    checks++; if (q.sequencing !== 1'b0) begin failures++; $display("FAIL idle_seq got=%b want=0", q.sequencing); end
    checks++; if (q.lft_out !== 16'sd1020) begin failures++; $display("FAIL idle_hold_lft got=%0d want=1020", q.lft_out); end
    checks++; if (q.rght_out !== -16'sd1020) begin failures++; $display("FAIL idle_hold_rght got=%0d want=-1020", q.rght_out); end
  endtask

  task automatic test_next_write();
    int nb;
    write_smpl(1021);
    capture(-1, 0, 0);
    checks++; if (cap_wait !== 1 || cap_len !== TAPS) begin failures++; $display("FAIL next_timing wait=%0d len=%0d want=1/%0d", cap_wait, cap_len, TAPS); end
    nb = burst_bad(1);
    checks++; if (nb !== 0) begin failures++; $display("FAIL next_data bad=%0d idx=%0d got=%0d want=%0d", nb, bad_idx, cap_l[bad_idx], 1 + bad_idx); end
  endtask

  task automatic test_write_during_burst();
    int nb;
    write_smpl(1022);
    capture(500, 1, 1023);
    checks++; if (cap_len !== TAPS) begin failures++; $display("FAIL wdb_len got=%0d want=%0d", cap_len, TAPS); end
    nb = burst_bad(2);
    checks++; if (nb !== 0) begin failures++; $display("FAIL wdb_data bad=%0d idx=%0d got=%0d want=%0d", nb, bad_idx, cap_l[bad_idx], 2 + bad_idx); end
    capture(TAPS - 2, 1, 1024);
    checks++; if (cap_wait !== 1) begin failures++; $display("FAIL pending_gap got=%0d want=1", cap_wait); end
    checks++; if (cap_len !== TAPS) begin failures++; $display("FAIL pending_len got=%0d want=%0d", cap_len, TAPS); end
    nb = burst_bad(3);
    checks++; if (nb !== 0) begin failures++; $display("FAIL pending_data bad=%0d idx=%0d got=%0d want=%0d", nb, bad_idx, cap_l[bad_idx], 3 + bad_idx); end
  endtask

  task automatic test_last_cycle_write();
    capture(0, 975, 1025);
    checks++; if (cap_wait !== 1) begin failures++; $display("FAIL lastcyc_gap got=%0d want=1", cap_wait); end
    checks++; if (cap_len !== TAPS) begin failures++; $display("FAIL lastcyc_len got=%0d want=%0d", cap_len, TAPS); end
    checks++; if (cap_l[0] !== 16'sd4) begin failures++; $display("FAIL lastcyc_first got=%0d want=4", cap_l[0]); end
  endtask

  task automatic test_wrap();
    int nb;
    capture(-1, 0, 0);
    checks++; if (cap_wait !== 1) begin failures++; $display("FAIL wrap_gap got=%0d want=1", cap_wait); end
    checks++; if (cap_len !== TAPS) begin failures++; $display("FAIL wrap_len got=%0d want=%0d", cap_len, TAPS); end
    nb = burst_bad(979);
    checks++; if (nb !== 0) begin failures++; $display("FAIL wrap_data bad=%0d idx=%0d got=%0d want=%0d", nb, bad_idx, cap_l[bad_idx], 979 + bad_idx); end
  endtask

  task automatic test_sign();
    write_smpl(32767);
    capture(-1, 0, 0);
    checks++; if (cap_wait !== 1 || cap_len !== TAPS) begin failures++; $display("FAIL sign_timing wait=%0d len=%0d", cap_wait, cap_len); end
    checks++; if (cap_l[0] !== 16'sd980 || cap_r[0] !== -16'sd980) begin failures++; $display("FAIL sign_first got=%0d/%0d want=980/-980", cap_l[0], cap_r[0]); end
    checks++; if (cap_l[TAPS-1] !== 16'sh7FFF) begin failures++; $display("FAIL sign_lft got=%h want=7fff", cap_l[TAPS-1]); end
    checks++; if (cap_r[TAPS-1] !== 16'sh8001) begin failures++; $display("FAIL sign_rght got=%h want=8001", cap_r[TAPS-1]); end
  endtask

  task automatic test_reset_mid_burst();
    int w = 0;
    int seen = 0;
    int nb;
    write_smpl(2000);
    while (q.sequencing !== 1'b1 && w < 100) begin step(); w++; end
    checks++; if (q.sequencing !== 1'b1) begin failures++; $display("FAIL rmb_start got=%b want=1", q.sequencing); end
    for (int i = 0; i < 300; i++) step();
    rst_n = 1'b0;
    #1;
    checks++; if (q.sequencing !== 1'b0 || q.lft_out !== 16'sd0 || q.rght_out !== 16'sd0) begin
      failures++; $display("FAIL rmb_async got=%b/%0d/%0d want=0/0/0", q.sequencing, q.lft_out, q.rght_out);
    end
    step();
    rst_n = 1'b1;
    step();
    for (int k = 0; k < TAPS - 1; k++) begin
      write_smpl(3000 + k);
      if (q.sequencing === 1'b1) seen++;
    end
    step();
    if (q.sequencing === 1'b1) seen++;
    checks++; if (seen !== 0) begin failures++; $display("FAIL rmb_refill high_cycles=%0d want=0", seen); end
    write_smpl(3000 + TAPS - 1);
    capture(-1, 0, 0);
    checks++; if (cap_wait !== 1 || cap_len !== TAPS) begin failures++; $display("FAIL rmb_timing wait=%0d len=%0d want=1/%0d", cap_wait, cap_len, TAPS); end
    nb = burst_bad(3000);
    checks++; if (nb !== 0) begin failures++; $display("FAIL rmb_data bad=%0d idx=%0d got=%0d want=%0d", nb, bad_idx, cap_l[bad_idx], 3000 + bad_idx); end
  endtask

  initial begin
    q.wrt_smpl  = 1'b0;
    q.lft_smpl  = '0;
    q.rght_smpl = '0;
    bad_idx = 0;
    test_reset();
    test_fill();
    test_first_burst();
    test_next_write();
    test_write_during_burst();
    test_last_cycle_write();
    test_wrap();
    test_sign();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
